// File: rtl/grp_bank_arbiter.sv
// Purpose : ping-pong owner control for the two group-buffer RAM banks between
//           the frame filler (writer) and the M8 frame former (reader).
// Latency : write path 1 clk (registered we/addr/data); read enables and read
//           address are combinational; the rd_data bank select trails rd_bank by
//           RD_LAT clk so it lines up with the RAM read latency.
// Backpressure: wr_ready drops once the writer completes a bank and stays low
//           until the reader swaps; writes or done pulses issued while wr_ready=0
//           are dropped (and flagged). A swap_req with no complete bank is refused.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data   writer strobe, address, data
//   wr_done                 pulse: writer finished the current write bank
//   wr_ready                writer may fill the write bank (registered)
//   rd_en/rd_addr           reader strobe and address
//   swap_req / swap_ack     reader asks for the next bank / swap performed (pulse)
//   rd_bank                 bank owned by the reader; the writer owns ~rd_bank
//   rd_data                 read data muxed from m0_q / m1_q
//   m0_we/m1_we             registered per-bank write enables
//   m0_re/m1_re             per-bank read enables
//   ram_wr_addr/ram_wr_data registered write address/data shared by both banks
//   ram_rd_addr             read address shared by both banks (= rd_addr)
//   m0_q/m1_q               bank read data
//   underrun_cnt            saturating count of refused swap_req pulses
//   wr_overrun              sticky: writer wrote or signalled done while not ready
//
// Build option: define GRP_UNDERRUN_STAT_EN to build underrun_cnt and wr_overrun;
// without it both outputs are tied to 0 and their registers do not exist.
// RD_LAT must be in 1..4.

module grp_bank_arbiter #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              rd_bank,
  output logic [DATA_W-1:0] rd_data,
  output logic              m0_we,
  output logic              m1_we,
  output logic              m0_re,
  output logic              m1_re,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] m0_q,
  input  logic [DATA_W-1:0] m1_q,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic              wr_overrun
);

  // S_FILL: writer is filling ~rd_bank.  S_HOLD: ~rd_bank is complete and
  // waits for the reader to take it.
  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state;

  // Bank ownership FSM. wr_ready and swap_ack are registered and decoded from
  // the transition, so they move one clk after wr_done / swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FILL;
      rd_bank  <= 1'b0;
      wr_ready <= 1'b1;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        S_FILL: begin
          if (wr_done && swap_req) begin
            // Bank completes exactly when the reader asks: hand it over at
            // once and let the writer start on the bank the reader released.
            rd_bank  <= ~rd_bank;
            swap_ack <= 1'b1;
          end else if (wr_done) begin
            state    <= S_HOLD;
            wr_ready <= 1'b0;
          end
          // swap_req alone is an underrun: the reader keeps its old bank.
        end
        S_HOLD: begin
          if (swap_req) begin
            rd_bank  <= ~rd_bank;
            swap_ack <= 1'b1;
            state    <= S_FILL;
            wr_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_FILL;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write path. The target bank is taken from rd_bank on the accepting cycle,
  // so a write coinciding with a swap still lands in the pre-swap write bank.
  logic wr_accept;
  assign wr_accept = wr_en & (state == S_FILL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_we       <= 1'b0;
      m1_we       <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      m0_we <= wr_accept & rd_bank;
      m1_we <= wr_accept & ~rd_bank;
      if (wr_accept) begin
        ram_wr_addr <= wr_addr;
        ram_wr_data <= wr_data;
      end
    end
  end

  // Read path: enables and address go straight to the banks.
  assign m0_re       = rd_en & ~rd_bank;
  assign m1_re       = rd_en & rd_bank;
  assign ram_rd_addr = rd_addr;

  // The data mux must follow the bank the read was issued to, not the current
  // owner, so reads in flight across a swap return old-bank data.
  logic [RD_LAT-1:0] rd_sel_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_pipe <= '0;
    end else begin
      rd_sel_pipe[0] <= rd_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_sel_pipe[i] <= rd_sel_pipe[i-1];
      end
    end
  end

  assign rd_data = rd_sel_pipe[RD_LAT-1] ? m1_q : m0_q;

`ifdef GRP_UNDERRUN_STAT_EN
  logic underrun_evt;
  logic overrun_evt;

  assign underrun_evt = (state == S_FILL) & swap_req & ~wr_done;
  assign overrun_evt  = (state == S_HOLD) & (wr_en | wr_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
      wr_overrun   <= 1'b0;
    end else begin
      if (underrun_evt && (underrun_cnt != {CNT_W{1'b1}})) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
      if (overrun_evt) begin
        wr_overrun <= 1'b1;
      end
    end
  end
`else
  assign underrun_cnt = '0;
  assign wr_overrun   = 1'b0;
`endif

endmodule

// File: doc/grp_bank_arbiter.md
Name: grp_bank_arbiter

Overview:
- Ping-pong controller for the two group-buffer RAM banks that sit between the frame filler (writer) and the M8 frame former (reader).
- Decides which bank each side owns, gates the per-bank read and write enables, and muxes the read data.
- Swaps the banks only when the writer has completed a bank; otherwise the reader re-reads the old bank.
- Counts underruns (reader asked to swap before a bank was ready) and flags writer overruns.

Parameters:
DATA_W, 12, RAM data width
ADDR_W, 10, RAM address width
RD_LAT, 1, RAM read latency in clk cycles (legal 1..4)
CNT_W, 8, underrun counter width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  writer write strobe
wr_addr  in  ADDR_W  writer address
wr_data  in  DATA_W  writer data
wr_done  in  1  one-cycle pulse: current write bank complete
wr_ready  out  1  writer may fill the write bank
rd_en  in  1  reader read strobe
rd_addr  in  ADDR_W  reader address
swap_req  in  1  one-cycle pulse: reader finished its frame and wants the next bank
swap_ack  out  1  one-cycle pulse: swap performed
rd_bank  out  1  bank currently owned by the reader
rd_data  out  DATA_W  read data, muxed from m0_q/m1_q
m0_we, m1_we  out  1  bank write enables (registered)
m0_re, m1_re  out  1  bank read enables
ram_wr_addr  out  ADDR_W  registered write address to both banks
ram_wr_data  out  DATA_W  registered write data to both banks
ram_rd_addr  out  ADDR_W  read address to both banks (equal to rd_addr)
m0_q, m1_q  in  DATA_W  bank read data
underrun_cnt  out  CNT_W  saturating count of swap_req pulses that found no full bank
wr_overrun  out  1  sticky: writer wrote or signalled done while not ready

Behaviour:
- Reset values:
  - FSM state S_FILL; rd_bank=0, so the write bank is 1.
  - wr_ready=1, swap_ack=0.
  - m0_we=m1_we=0; ram_wr_addr=0, ram_wr_data=0.
  - underrun_cnt=0, wr_overrun=0.
  - RD_LAT select pipeline cleared to 0.
- Write bank is always ~rd_bank.
- Write path, latency 1 clk: on a cycle with wr_en=1 and state S_FILL:
  - next cycle, the write enable of bank ~rd_bank (as sampled on that cycle) is 1;
  - ram_wr_addr/ram_wr_data carry the sampled wr_addr/wr_data.
  - Otherwise both write enables are 0.
- Read path, combinational:
  - m0_re = rd_en & ~rd_bank; m1_re = rd_en & rd_bank.
  - ram_rd_addr = rd_addr.
  - rd_bank is delayed through an RD_LAT-deep shift register. rd_data selects m1_q when the delayed value is 1, else m0_q.
  - Reads already in flight at a swap therefore return data from the old bank.
- FSM states:
  - S_FILL:
    - wr_ready=1.
    - wr_done alone -> S_HOLD.
    - swap_req alone -> underrun: no toggle, underrun_cnt+1 (saturates at all-ones), swap_ack=0, stay in S_FILL.
    - wr_done and swap_req on the same cycle -> toggle rd_bank, swap_ack=1, stay in S_FILL. The writer starts the other bank immediately.
  - S_HOLD:
    - wr_ready=0.
    - wr_en is dropped and sets wr_overrun; wr_done also sets wr_overrun.
    - swap_req -> toggle rd_bank, swap_ack=1 next cycle, go to S_FILL.
- wr_ready is a registered, state-decoded output: it changes the cycle after wr_done or swap.
- A write registered on the same cycle as a swap lands in the bank that was the write bank before the swap. The registered enable captures the bank.
- wr_overrun clears only on reset.
- Reset asserted mid-operation: all state returns to reset values asynchronously and any pending registered write is cancelled.

Optional Feature:
- Macro GRP_UNDERRUN_STAT_EN.
- Defined: the underrun_cnt and wr_overrun logic is present as described.
- Undefined: both outputs are tied to 0 and their registers are not built. Swap and FSM behaviour is unchanged.

Test Plan:
- Reset, then idle 10 clk -> rd_bank=0, wr_ready=1, all we/re=0, underrun_cnt=0.
- Write addr 5 data 0xABC, then pulse wr_done, then swap_req -> m1_we=1 one clk after wr_en with addr 5/0xABC. wr_ready falls after wr_done. swap_ack pulses, rd_bank=1. A read of addr 5 with RD_LAT=1 returns 0xABC the next clk.
- swap_req in S_FILL, repeated 300 times with CNT_W=8 -> rd_bank stays 0, underrun_cnt saturates at 255, swap_ack never pulses.
- wr_done and swap_req on the same clk -> rd_bank toggles, state stays S_FILL, wr_ready stays 1, underrun_cnt unchanged.
- wr_en in S_HOLD -> no bank write enable asserted, wr_overrun=1 and held until reset.
- RD_LAT=3, rd_en held across a swap -> the three reads issued before the swap return m0_q data, later reads return m1_q. Reset mid-burst -> all outputs at reset values in the same cycle.
